dest_pipeline_tracker: RTL and testbench
========================================

DEST_PIPELINE_TRACKER -- requirements
Module: dest_pipeline_tracker

Interface
REQ-001 Ports SHALL be one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  decode stage holds a valid instruction.
REQ-005 id_opcode  in  7  decode-stage opcode, encoded per defines.v.
REQ-006 id_dest / id_src1 / id_src2  in  3 each  decode-stage register fields.
REQ-007 flush  in  1  branch taken; kill decode and R1 contents.
REQ-008 r1_destination / r2_destination  out  3 each  destination held in R1 / R2.
REQ-009 write_en / r2_write_en  out  1 each  R1 / R2 instruction writes a register.
REQ-010 stall  out  1  hold PC and decode this cycle.
REQ-011 halted  out  1  pipeline drained after HALT.

Function
REQ-012 Writing opcodes SHALL be the following:
- ADD, ADDF, SUB, SUBF
- AND, OR, XOR, NAND, NOR, NXOR
- SHIFTR, SHIFTRA, SHIFTL
- LOAD, LOADC
REQ-013 No other opcode SHALL write a register, including NOP, HALT, STORE and all jumps.
REQ-014 src1 SHALL be read by the following, and by no other opcode:
- arithmetic, logic and shift opcodes
- LOADC, STORE, JMPcond, JMPRcond
REQ-015 src2 SHALL be read by the following, and by no other opcode:
- arithmetic and logic opcodes
- LOAD, STORE, JMP, JMPcond
REQ-016 On each edge with stall=0, R1 SHALL capture the following fields:
- id_dest
- write flag = id_valid & writing(id_opcode)
- load flag = id_valid & (id_opcode==LOAD)
REQ-017 R2 SHALL capture R1 on every edge, regardless of stall.
REQ-018 Load-use: stall SHALL be 1 combinationally when all of the following hold:
- R1 load flag = 1 and write_en = 1
- id_valid = 1
- r1_destination matches an id source the opcode actually reads
REQ-019 While stall=1, R1 SHALL load a bubble on the next edge: write flag 0, load flag 0, destination unchanged.
REQ-020 Stall length SHALL be exactly one cycle per load-use hazard; the following cycle's re-check SHALL not re-stall.
REQ-021 flush=1 SHALL force the next R1 to a bubble and suppress stall in the same cycle; flush SHALL have priority over stall.
REQ-022 The FSM SHALL have three states: RUN, DRAIN, HALTED.
- RUN->DRAIN when id_valid & HALT & !stall & !flush; the HALT itself enters R1 as a bubble.
- DRAIN SHALL last exactly 2 cycles via a 2-bit counter, feeding bubbles into R1, then go to HALTED.
- HALTED SHALL be terminal until reset; halted=1, stall=1, R1/R2 write flags 0.
REQ-023 In DRAIN and HALTED, id inputs SHALL be ignored and stall SHALL be held at 1.
REQ-024 Register 0 SHALL receive no special handling; destination 0 is tracked like any other.

Reset
REQ-025 rst_n=0 SHALL asynchronously set the following:
- r1_destination=0, r2_destination=0
- write_en=0, r2_write_en=0, R1 load flag=0
- FSM=RUN, counter=0, halted=0
REQ-026 stall SHALL be 0 while in reset.
REQ-027 Reset asserted mid-stall or mid-DRAIN SHALL return the block to RUN with no residual bubble or count.

Structure
REQ-028 Opcode field macros, classification codes and the FSM state encodings SHALL live in shared defines.v.
REQ-029 Writing/reads-src1/reads-src2 decode SHALL be one sub-module, opcode_usage_decode (opcode in; writes, rd_src1, rd_src2, is_load, is_halt out), reusable by the forwarding logic.
REQ-030 Outputs SHALL be driven directly from registers, except stall, which is combinational from R1 state, id inputs and FSM state.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Back-to-back ALU: ADD dest=3 then SUB src1=3 -> stall=0; cycle 1 write_en=1, r1_destination=3; cycle 2 r2_write_en=1, r2_destination=3.
- Load-use: LOAD dest=5 then ADD src2=5 -> stall=1 for exactly one cycle; bubble in R1 (write_en=0); R2 then shows dest 5 with r2_write_en=1.
- Non-reading source: LOAD dest=2 then SHIFTL src2=2 (src2 unread) -> stall=0.
- Flush priority: LOAD dest=1 then JMPcond src1=1 with flush=1 -> stall=0; next R1 write_en=0.
- HALT: HALT issued after ADD dest=4 -> stall=1 immediately; ADD retires through R2; halted=1 on the third edge after HALT capture; remains until rst_n.
- Async reset: rst_n=0 between edges during the load-use stall -> all outputs 0 at once; FSM=RUN after release.

Source files
------------

// File: rtl/dest_pipeline_tracker_pkg.sv
// Shared opcode encodings, FSM state encoding and pipeline-register layout for
// the destination tracker and its opcode usage decoder.
package dest_pipeline_tracker_pkg;

    localparam int OPCODE_W = 7;
    localparam int REG_W    = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP      = 7'h00;
    localparam logic [OPCODE_W-1:0] OP_ADD      = 7'h01;
    localparam logic [OPCODE_W-1:0] OP_ADDF     = 7'h02;
    localparam logic [OPCODE_W-1:0] OP_SUB      = 7'h03;
    localparam logic [OPCODE_W-1:0] OP_SUBF     = 7'h04;
    localparam logic [OPCODE_W-1:0] OP_AND      = 7'h05;
    localparam logic [OPCODE_W-1:0] OP_OR       = 7'h06;
    localparam logic [OPCODE_W-1:0] OP_XOR      = 7'h07;
    localparam logic [OPCODE_W-1:0] OP_NAND     = 7'h08;
    localparam logic [OPCODE_W-1:0] OP_NOR      = 7'h09;
    localparam logic [OPCODE_W-1:0] OP_NXOR     = 7'h0A;
    localparam logic [OPCODE_W-1:0] OP_SHIFTR   = 7'h0B;
    localparam logic [OPCODE_W-1:0] OP_SHIFTRA  = 7'h0C;
    localparam logic [OPCODE_W-1:0] OP_SHIFTL   = 7'h0D;
    localparam logic [OPCODE_W-1:0] OP_LOAD     = 7'h0E;
    localparam logic [OPCODE_W-1:0] OP_LOADC    = 7'h0F;
    localparam logic [OPCODE_W-1:0] OP_STORE    = 7'h10;
    localparam logic [OPCODE_W-1:0] OP_JMP      = 7'h11;
    localparam logic [OPCODE_W-1:0] OP_JMPR     = 7'h12;
    localparam logic [OPCODE_W-1:0] OP_JMPCOND  = 7'h13;
    localparam logic [OPCODE_W-1:0] OP_JMPRCOND = 7'h14;
    localparam logic [OPCODE_W-1:0] OP_HALT     = 7'h15;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // DRAIN covers two cycles: counter values 0 and 1.
    localparam logic [1:0] DRAIN_LAST = 2'd1;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wr;
        logic             load;
    } r1_t;

    function automatic r1_t bubble_of(input r1_t cur);
        r1_t b;
        b      = cur;
        b.wr   = 1'b0;
        b.load = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/dest_pipeline_tracker_opcode_usage_decode.sv
// Classifies an opcode by register usage: writes a destination, reads src1/src2,
// and flags LOAD and HALT. Shared with the forwarding logic.
module opcode_usage_decode
    import dest_pipeline_tracker_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic                writes,
    output logic                rd_src1,
    output logic                rd_src2,
    output logic                is_load,
    output logic                is_halt
);

    always_comb begin
        writes  = 1'b0;
        rd_src1 = 1'b0;
        rd_src2 = 1'b0;
        is_load = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDF, OP_SUB, OP_SUBF,
            OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_NXOR: begin
                writes  = 1'b1;
                rd_src1 = 1'b1;
                rd_src2 = 1'b1;
            end
            OP_SHIFTR, OP_SHIFTRA, OP_SHIFTL: begin
                writes  = 1'b1;
                rd_src1 = 1'b1;
            end
            OP_LOAD: begin
                writes  = 1'b1;
                rd_src2 = 1'b1;
                is_load = 1'b1;
            end
            OP_LOADC: begin
                writes  = 1'b1;
                rd_src1 = 1'b1;
            end
            OP_STORE: begin
                rd_src1 = 1'b1;
                rd_src2 = 1'b1;
            end
            OP_JMP: begin
                rd_src2 = 1'b1;
            end
            OP_JMPCOND: begin
                rd_src1 = 1'b1;
                rd_src2 = 1'b1;
            end
            OP_JMPRCOND: begin
                rd_src1 = 1'b1;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dest_pipeline_tracker.sv
// Tracks destination registers through the two stages after decode (R1, R2),
// raises a one-cycle load-use stall, and drains the pipeline after HALT.
module dest_pipeline_tracker
    import dest_pipeline_tracker_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_dest,
    input  logic [REG_W-1:0]    id_src1,
    input  logic [REG_W-1:0]    id_src2,
    input  logic                flush,
    output logic [REG_W-1:0]    r1_destination,
    output logic [REG_W-1:0]    r2_destination,
    output logic                write_en,
    output logic                r2_write_en,
    output logic                stall,
    output logic                halted
);

    logic dec_writes;
    logic dec_rd_src1;
    logic dec_rd_src2;
    logic dec_is_load;
    logic dec_is_halt;

    opcode_usage_decode u_decode (
        .opcode  (id_opcode),
        .writes  (dec_writes),
        .rd_src1 (dec_rd_src1),
        .rd_src2 (dec_rd_src2),
        .is_load (dec_is_load),
        .is_halt (dec_is_halt)
    );

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       drain_cnt_q;
    logic [1:0]       drain_cnt_d;
    logic             halted_q;
    r1_t              r1_p1;
    r1_t              r1_d;
    logic [REG_W-1:0] dest_p2;
    logic             wr_p2;

    logic src_match;
    logic load_use;
    logic halt_accept;

    // A bubble left in R1 by a stall has load=0, so the re-check cannot re-stall.
    assign src_match   = (dec_rd_src1 && (id_src1 == r1_p1.dest)) ||
                         (dec_rd_src2 && (id_src2 == r1_p1.dest));
    assign load_use    = r1_p1.load && r1_p1.wr && id_valid && src_match;
    assign halt_accept = id_valid && dec_is_halt && !load_use && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 2'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= (state_d == ST_HALTED);
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (halt_accept) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 2'd0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = 2'd0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            ST_HALTED: begin
                state_d     = ST_HALTED;
                drain_cnt_d = 2'd0;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = 2'd0;
            end
        endcase
    end

    // Flush outranks the hazard; HALT enters R1 as a bubble.
    always_comb begin
        stall = 1'b0;
        r1_d  = bubble_of(r1_p1);
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    r1_d = bubble_of(r1_p1);
                end else if (load_use) begin
                    stall = 1'b1;
                    r1_d  = bubble_of(r1_p1);
                end else if (id_valid && dec_is_halt) begin
                    r1_d = bubble_of(r1_p1);
                end else begin
                    r1_d.dest = id_dest;
                    r1_d.wr   = id_valid && dec_writes;
                    r1_d.load = id_valid && dec_is_load;
                end
            end
            ST_DRAIN, ST_HALTED: begin
                stall = 1'b1;
                r1_d  = bubble_of(r1_p1);
            end
            default: begin
                stall = 1'b0;
                r1_d  = bubble_of(r1_p1);
            end
        endcase
    end

    // R1 stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_p1 <= '0;
        end else begin
            r1_p1 <= r1_d;
        end
    end

    // R2 stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_p2 <= '0;
            wr_p2   <= 1'b0;
        end else begin
            dest_p2 <= r1_p1.dest;
            wr_p2   <= r1_p1.wr;
        end
    end

    assign r1_destination = r1_p1.dest;
    assign write_en       = r1_p1.wr;
    assign r2_destination = dest_p2;
    assign r2_write_en    = wr_p2;
    assign halted         = halted_q;

endmodule

// File: tb/tb_dest_pipeline_tracker.sv
// Directed bench for dest_pipeline_tracker: ALU back-to-back, load-use stall,
// unread sources, flush priority, register 0, async reset, and HALT drain.
module tb_dest_pipeline_tracker;
    import dest_pipeline_tracker_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                id_valid;
    logic [OPCODE_W-1:0] id_opcode;
    logic [REG_W-1:0]    id_dest;
    logic [REG_W-1:0]    id_src1;
    logic [REG_W-1:0]    id_src2;
    logic                flush;
    logic [REG_W-1:0]    r1_destination;
    logic [REG_W-1:0]    r2_destination;
    logic                write_en;
    logic                r2_write_en;
    logic                stall;
    logic                halted;

    int checks;
    int failures;

    dest_pipeline_tracker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_dest        (id_dest),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .flush          (flush),
        .r1_destination (r1_destination),
        .r2_destination (r2_destination),
        .write_en       (write_en),
        .r2_write_en    (r2_write_en),
        .stall          (stall),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [OPCODE_W-1:0] op, input logic [REG_W-1:0] d,
                         input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2, input logic fl);
        id_valid  = v;
        id_opcode = op;
        id_dest   = d;
        id_src1   = s1;
        id_src2   = s2;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_r1d"},   {5'd0, r1_destination}, 8'd0);
        check({tag, "_r2d"},   {5'd0, r2_destination}, 8'd0);
        check({tag, "_wen"},   {7'd0, write_en},       8'd0);
        check({tag, "_r2wen"}, {7'd0, r2_write_en},    8'd0);
        check({tag, "_stall"}, {7'd0, stall},          8'd0);
        check({tag, "_halt"},  {7'd0, halted},         8'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0);
        #2;
        check_all_zero("reset");
        tick();
        #2 rst_n = 1'b1;

        // Back-to-back ALU: ADD r3 then SUB reading r3
        drive(1'b1, OP_ADD, 3'd3, 3'd0, 3'd0, 1'b0);
        tick();
        check("alu_c1_wen", {7'd0, write_en}, 8'd1);
        check("alu_c1_r1d", {5'd0, r1_destination}, 8'd3);
        drive(1'b1, OP_SUB, 3'd6, 3'd3, 3'd1, 1'b0);
        check("alu_stall", {7'd0, stall}, 8'd0);
        tick();
        check("alu_c2_r2wen", {7'd0, r2_write_en}, 8'd1);
        check("alu_c2_r2d", {5'd0, r2_destination}, 8'd3);
        check("alu_c2_r1d", {5'd0, r1_destination}, 8'd6);

        // Load-use: LOAD r5 then ADD reading r5 on src2
        drive(1'b1, OP_LOAD, 3'd5, 3'd0, 3'd0, 1'b0);
        check("lu_load_nostall", {7'd0, stall}, 8'd0);
        tick();
        check("lu_load_wen", {7'd0, write_en}, 8'd1);
        drive(1'b1, OP_ADD, 3'd7, 3'd0, 3'd5, 1'b0);
        check("lu_stall", {7'd0, stall}, 8'd1);
        tick();
        check("lu_bubble_wen", {7'd0, write_en}, 8'd0);
        check("lu_bubble_r1d", {5'd0, r1_destination}, 8'd5);
        check("lu_r2d", {5'd0, r2_destination}, 8'd5);
        check("lu_r2wen", {7'd0, r2_write_en}, 8'd1);
        check("lu_recheck_stall", {7'd0, stall}, 8'd0);
        tick();
        check("lu_add_wen", {7'd0, write_en}, 8'd1);
        check("lu_add_r1d", {5'd0, r1_destination}, 8'd7);
        check("lu_bubble_r2wen", {7'd0, r2_write_en}, 8'd0);

        // Non-reading source: SHIFTL does not read src2, does read src1
        drive(1'b1, OP_LOAD, 3'd2, 3'd0, 3'd0, 1'b0);
        tick();
        drive(1'b1, OP_SHIFTL, 3'd1, 3'd0, 3'd2, 1'b0);
        check("shl_src2_stall", {7'd0, stall}, 8'd0);
        drive(1'b1, OP_SHIFTL, 3'd1, 3'd2, 3'd0, 1'b0);
        check("shl_src1_stall", {7'd0, stall}, 8'd1);
        drive(1'b1, OP_SHIFTL, 3'd1, 3'd0, 3'd2, 1'b0);
        tick();
        check("shl_wen", {7'd0, write_en}, 8'd1);
        check("shl_r1d", {5'd0, r1_destination}, 8'd1);

        // Flush priority over a load-use hazard
        drive(1'b1, OP_LOAD, 3'd1, 3'd0, 3'd0, 1'b0);
        tick();
        drive(1'b1, OP_JMPCOND, 3'd0, 3'd1, 3'd0, 1'b0);
        check("fl_hazard_stall", {7'd0, stall}, 8'd1);
        drive(1'b1, OP_JMPCOND, 3'd0, 3'd1, 3'd0, 1'b1);
        check("fl_stall", {7'd0, stall}, 8'd0);
        tick();
        check("fl_wen", {7'd0, write_en}, 8'd0);
        check("fl_r2wen", {7'd0, r2_write_en}, 8'd1);
        check("fl_r2d", {5'd0, r2_destination}, 8'd1);

        // Register 0 is tracked like any other destination
        drive(1'b1, OP_LOAD, 3'd0, 3'd0, 3'd0, 1'b0);
        tick();
        drive(1'b1, OP_ADD, 3'd3, 3'd0, 3'd4, 1'b0);
        check("r0_stall", {7'd0, stall}, 8'd1);
        tick();

        // Async reset in the middle of a load-use stall
        drive(1'b1, OP_ADD, 3'd6, 3'd0, 3'd0, 1'b0);
        tick();
        drive(1'b1, OP_LOAD, 3'd5, 3'd0, 3'd0, 1'b0);
        tick();
        drive(1'b1, OP_ADD, 3'd7, 3'd5, 3'd0, 1'b0);
        check("ar_pre_stall", {7'd0, stall}, 8'd1);
        check("ar_pre_r2wen", {7'd0, r2_write_en}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("ar");
        tick();
        #2 rst_n = 1'b1;
        #1;
        check("ar_post_stall", {7'd0, stall}, 8'd0);
        tick();
        check("ar_post_wen", {7'd0, write_en}, 8'd1);
        check("ar_post_r1d", {5'd0, r1_destination}, 8'd7);

        // HALT after ADD r4: drain two cycles, then halted until reset
        drive(1'b1, OP_ADD, 3'd4, 3'd0, 3'd0, 1'b0);
        tick();
        drive(1'b1, OP_HALT, 3'd0, 3'd0, 3'd0, 1'b0);
        check("h_decode_stall", {7'd0, stall}, 8'd0);
        tick();
        drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0);
        check("h_e1_stall", {7'd0, stall}, 8'd1);
        check("h_e1_halted", {7'd0, halted}, 8'd0);
        check("h_e1_wen", {7'd0, write_en}, 8'd0);
        check("h_e1_r2wen", {7'd0, r2_write_en}, 8'd1);
        check("h_e1_r2d", {5'd0, r2_destination}, 8'd4);
        tick();
        check("h_e2_halted", {7'd0, halted}, 8'd0);
        check("h_e2_stall", {7'd0, stall}, 8'd1);
        check("h_e2_r2wen", {7'd0, r2_write_en}, 8'd0);
        drive(1'b1, OP_LOAD, 3'd3, 3'd0, 3'd0, 1'b0);
        tick();
        check("h_e3_halted", {7'd0, halted}, 8'd1);
        check("h_e3_wen", {7'd0, write_en}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_ADD, 3'(i + 1), 3'd0, 3'd0, 1'b0);
            tick();
            check("h_hold_halted", {7'd0, halted}, 8'd1);
            check("h_hold_stall", {7'd0, stall}, 8'd1);
            check("h_hold_wen", {7'd0, write_en}, 8'd0);
            check("h_hold_r2wen", {7'd0, r2_write_en}, 8'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("hr");
        tick();
        #2 rst_n = 1'b1;
        drive(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 1'b0);
        check("hr_post_stall", {7'd0, stall}, 8'd0);
        tick();
        check("hr_post_wen", {7'd0, write_en}, 8'd1);
        check("hr_post_r1d", {5'd0, r1_destination}, 8'd2);
        check("hr_post_halted", {7'd0, halted}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
